clk_enable_divider: RTL and testbench

- Parametrised multi-channel clock-enable generator; successor to the fixed MMCM-based clock divider.
- Produces NUM_CH single-cycle tick enables and matching 50%-duty square waves from one system clock, so downstream logic stays in one clock domain.
- Divisors are runtime-programmable and change glitch-free; a sync input realigns all channels; `locked` mirrors the MMCM lock semantics.
- Sits between the top module and the slow-rate consumers (display scan, debounce, UART baud, etc.).

---
 rtl/clk_enable_divider.sv | 161 ++++++++++++++++
 tb/tb_clk_enable_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_divider.sv
// Multi-channel clock-enable generator: per-channel tick pulses and 50%-duty square
// waves from one system clock, with glitch-free runtime divisor updates and realignment.

module clk_enable_divider_ch #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync,
  input  logic                 wr_hit,
  input  logic [DIV_WIDTH-1:0] wr_div,
  output logic                 tick,
  output logic                 sq,
  output logic                 seen,
  output logic [DIV_WIDTH-1:0] div
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;
  logic                 tick_q, tick_d;
  logic                 sq_q, sq_d;
  logic                 seen_q, seen_d;
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 term;

  // Divisors 0 and 1 both mean "every enabled cycle".
  assign eff_div = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign term    = (cnt_q == eff_div - DIV_WIDTH'(1));

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;
    seen_d   = seen_q;
    if (sync) begin
      cnt_d    = '0;
      sq_d     = 1'b0;
      seen_d   = 1'b0;
      pend_v_d = 1'b0;
      if (wr_hit)        div_d = wr_div;
      else if (pend_v_q) div_d = pend_q;
    end else begin
      if (wr_hit) begin
        pend_d   = wr_div;
        pend_v_d = 1'b1;
      end
      if (enable) begin
        if (term) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
          seen_d = 1'b1;
          // New divisor only takes effect at a period boundary; a same-cycle write wins.
          if (wr_hit) begin
            div_d    = wr_div;
            pend_v_d = 1'b0;
          end else if (pend_v_q) begin
            div_d    = pend_q;
            pend_v_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
      seen_q   <= seen_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign seen = seen_q;
  assign div  = div_q;
endmodule

module clk_enable_divider #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int CH_ADDR_W   = 2,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync,
  input  logic                 wr_en,
  input  logic [CH_ADDR_W-1:0] wr_ch,
  input  logic [DIV_WIDTH-1:0] wr_div,
  output logic [DIV_WIDTH-1:0] rd_div,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    sq,
  output logic                 locked
);
  logic [NUM_CH-1:0]                wr_hit;
  logic [NUM_CH-1:0]                seen;
  logic [NUM_CH-1:0][DIV_WIDTH-1:0] div_all;
  logic                             locked_q, locked_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Channel numbers >= NUM_CH never match, so such writes fall on the floor.
    assign wr_hit[i] = wr_en && (wr_ch == CH_ADDR_W'(i));

    clk_enable_divider_ch #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .sync   (sync),
      .wr_hit (wr_hit[i]),
      .wr_div (wr_div),
      .tick   (tick[i]),
      .sq     (sq[i]),
      .seen   (seen[i]),
      .div    (div_all[i])
    );
  end

  always_comb begin
    rd_div = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_ADDR_W'(i)) rd_div = div_all[i];
    end
  end

  always_comb begin
    locked_d = sync ? 1'b0 : &seen;
  end

  always_ff @(posedge clk) begin
    if (reset) locked_q <= 1'b0;
    else       locked_q <= locked_d;
  end

  assign locked = locked_q;
endmodule

// File: tb/tb_clk_enable_divider.sv
// Directed bench for clk_enable_divider: a per-channel elapsed-cycle model checked every
// cycle, plus literal expectations at hand-computed edges.

module tb_clk_enable_divider;
  localparam int NC  = 4;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          reset, enable, sync, wr_en;
  logic [AW-1:0] wr_ch;
  logic [DW-1:0] wr_div;
  logic [DW-1:0] rd_div;
  logic [NC-1:0] tick, sq;
  logic          locked;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_enable_divider #(
    .NUM_CH(NC), .DIV_WIDTH(DW), .CH_ADDR_W(AW), .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .rd_div(rd_div), .tick(tick), .sq(sq), .locked(locked)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each channel counts enabled cycles elapsed in its current period and
  // ticks when that reaches the period length.
  int            m_el[NC], m_div[NC], m_pend[NC];
  bit            m_pv[NC], m_seen[NC];
  logic [NC-1:0] m_tick, m_sq;
  bit            m_lock;
  bit            mvalid = 0;

  task automatic model_step();
    bit all_seen;
    bit hit;
    int per;
    all_seen = 1;
    for (int c = 0; c < NC; c++) all_seen &= m_seen[c];
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        m_el[c] = 0; m_div[c] = DEF; m_pend[c] = 0; m_pv[c] = 0; m_seen[c] = 0;
      end
      m_tick = '0; m_sq = '0; m_lock = 0; mvalid = 1;
      return;
    end
    m_lock = sync ? 1'b0 : all_seen;
    for (int c = 0; c < NC; c++) begin
      hit = wr_en && (int'(wr_ch) == c);
      m_tick[c] = 1'b0;
      if (sync) begin
        m_el[c] = 0; m_sq[c] = 1'b0; m_seen[c] = 0;
        if (hit)          m_div[c] = int'(wr_div);
        else if (m_pv[c]) m_div[c] = m_pend[c];
        m_pv[c] = 0;
      end else begin
        if (hit) begin m_pend[c] = int'(wr_div); m_pv[c] = 1; end
        if (enable) begin
          per = (m_div[c] < 1) ? 1 : m_div[c];
          m_el[c]++;
          if (m_el[c] >= per) begin
            m_el[c] = 0; m_tick[c] = 1'b1; m_sq[c] = ~m_sq[c]; m_seen[c] = 1;
            if (hit) begin m_div[c] = int'(wr_div); m_pv[c] = 0; end
            else if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 0; end
          end
        end
      end
    end
  endtask

  // Compare process: inputs change on negedges, so at posedge+1 they are exactly
  // what the DUT sampled.
  always begin
    int exp_rd;
    @(posedge clk);
    #1;
    model_step();
    if (mvalid) begin
      exp_rd = (int'(wr_ch) < NC) ? m_div[wr_ch] : 0;
      chk("m_tick",   32'(tick),   32'(m_tick));
      chk("m_sq",     32'(sq),     32'(m_sq));
      chk("m_locked", 32'(locked), 32'(m_lock));
      chk("m_rd_div", 32'(rd_div), 32'(exp_rd));
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1; enable = 0; sync = 0; wr_en = 0; wr_ch = '0; wr_div = '0;
    go(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sq", 32'(sq), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_rd_div", 32'(rd_div), 4);
    reset = 0; enable = 1;

    // Default divisor 4: ticks at edges 4, 8, 12
    go(3); chk("e3_tick", 32'(tick), 0);
    go(1); chk("e4_tick", 32'(tick), 'hF); chk("e4_sq", 32'(sq), 'hF); chk("e4_locked", 32'(locked), 0);
    go(1); chk("e5_tick", 32'(tick), 0); chk("e5_locked", 32'(locked), 1);
    go(3); chk("e8_tick", 32'(tick), 'hF); chk("e8_sq", 32'(sq), 0);

    // Ch1 at cnt=1: write 3, old period completes first
    go(1); wr_en = 1; wr_ch = 1; wr_div = 3;
    go(1); wr_en = 0; chk("e10_rd", 32'(rd_div), 4); chk("e10_tick", 32'(tick), 0);
    go(1); chk("e11_rd", 32'(rd_div), 4);
    go(1); chk("e12_tick", 32'(tick), 'hF); chk("e12_rd", 32'(rd_div), 3);
    go(3); chk("e15_tick", 32'(tick), 'b0010);
    go(1); chk("e16_tick", 32'(tick), 'b1101);

    // Divisor 0 on ch2, 1 on ch3, each followed by sync
    wr_en = 1; wr_ch = 2; wr_div = 0;
    go(1); wr_en = 0; sync = 1;
    go(1); chk("e18_tick", 32'(tick), 0); chk("e18_sq", 32'(sq), 0); chk("e18_locked", 32'(locked), 0);
    sync = 0; wr_en = 1; wr_ch = 3; wr_div = 1;
    go(1); chk("e19_tick", 32'(tick), 'b0100);
    wr_en = 0; sync = 1;
    go(1); chk("e20_tick", 32'(tick), 0);
    sync = 0;
    go(1); chk("e21_tick", 32'(tick), 'b1100); chk("e21_sq", 32'(sq), 'b1100);
    go(1); chk("e22_tick", 32'(tick), 'b1100); chk("e22_sq", 32'(sq), 'b0000);
    go(1); chk("e23_tick", 32'(tick), 'b1110);
    go(1); chk("e24_tick", 32'(tick), 'b1101); chk("e24_locked", 32'(locked), 0);
    go(1); chk("e25_locked", 32'(locked), 1);

    // Sync mid-period with same-cycle write ch0=5
    sync = 1; wr_en = 1; wr_ch = 0; wr_div = 5;
    go(1);
    chk("e26_tick", 32'(tick), 0); chk("e26_sq", 32'(sq), 0);
    chk("e26_locked", 32'(locked), 0); chk("e26_rd", 32'(rd_div), 5);
    sync = 0; wr_en = 0;
    go(4); chk("e30_tick", 32'(tick), 'b1100); chk("e30_locked", 32'(locked), 0);
    go(1); chk("e31_tick", 32'(tick), 'b1101); chk("e31_locked", 32'(locked), 0);
    go(1); chk("e32_locked", 32'(locked), 1); chk("e32_tick", 32'(tick), 'b1110);

    // Back to D=4 on ch0 (applied at its wrap at edge 36), then disable at cnt=2
    wr_en = 1; wr_ch = 0; wr_div = 4;
    go(1); wr_en = 0;
    go(5); chk("e38_rd", 32'(rd_div), 4); chk("e38_sq", 32'(sq), 0);
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      go(1);
      chk("dis_tick", 32'(tick), 0);
      chk("dis_sq", 32'(sq), 0);
      chk("dis_rd", 32'(rd_div), 4);
    end
    enable = 1;
    go(1); chk("e44_tick", 32'(tick), 'b1100);
    go(1); chk("e45_tick", 32'(tick), 'b1101); chk("e45_sq", 32'(sq), 'b0001);

    // Pending write to ch1 discarded by reset
    wr_en = 1; wr_ch = 1; wr_div = 7;
    go(1); wr_en = 0; reset = 1;
    go(1);
    chk("e47_tick", 32'(tick), 0); chk("e47_sq", 32'(sq), 0);
    chk("e47_locked", 32'(locked), 0); chk("e47_rd", 32'(rd_div), 4);
    reset = 0;
    go(3); chk("e50_tick", 32'(tick), 0);
    go(1); chk("e51_tick", 32'(tick), 'hF);
    go(4); chk("e55_tick", 32'(tick), 'hF); chk("e55_rd", 32'(rd_div), 4);

    // Out-of-range channel: ignored, reads back 0
    wr_en = 1; wr_ch = 3'(NC); wr_div = 9;
    #1 chk("oob_rd", 32'(rd_div), 0);
    go(1); wr_en = 0;
    for (int c = 0; c < NC; c++) begin
      wr_ch = 3'(c);
      #1 chk("oob_after_rd", 32'(rd_div), 4);
    end
    go(3); chk("e59_tick", 32'(tick), 'hF);
    go(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
